// File: rtl/ecc_20_chk_pipe.sv
// ecc_20_chk_pipe: registered read-path check stage for 20-bit SECDED storage.
// A stored word (20 data + 6 parity) is decoded by ecc_20_cal on the input
// side and handed downstream through a two-entry valid/ready skid buffer.
// Optional error logging (saturating counters, first-error capture, irq) is
// compiled in when ECC_20_CHK_ERR_LOG_EN is defined; otherwise those outputs
// are tied to 0 and clr_log is ignored.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. A producer holding valid keeps its payload stable until the
// transfer; ready never depends combinationally on valid on either side.

// ecc_20_cal: Hamming SECDED encoder/decoder for 20 data bits.
// Data bits sit at codeword positions 1..25 that are not powers of two, in
// ascending order. parity_out[4:0] are the Hamming checks over those
// positions; parity_out[5] is the overall parity of data and the five checks.
module ecc_20_cal (
  input  logic [19:0] data_in,
  input  logic [5:0]  parity_in,
  output logic [5:0]  parity_out,
  output logic [5:0]  syndrome,
  output logic [19:0] data_out,
  output logic        sbit_err,
  output logic        dbit_err
);

  // Codeword position of each data bit.
  function automatic logic [4:0] data_pos(input int idx);
    logic [4:0] pos;
    pos = 5'd0;
    case (idx)
      0:  pos = 5'd3;
      1:  pos = 5'd5;
      2:  pos = 5'd6;
      3:  pos = 5'd7;
      4:  pos = 5'd9;
      5:  pos = 5'd10;
      6:  pos = 5'd11;
      7:  pos = 5'd12;
      8:  pos = 5'd13;
      9:  pos = 5'd14;
      10: pos = 5'd15;
      11: pos = 5'd17;
      12: pos = 5'd18;
      13: pos = 5'd19;
      14: pos = 5'd20;
      15: pos = 5'd21;
      16: pos = 5'd22;
      17: pos = 5'd23;
      18: pos = 5'd24;
      19: pos = 5'd25;
      default: pos = 5'd0;
    endcase
    return pos;
  endfunction

  logic [4:0]  enc_pos;
  logic [4:0]  dec_pos;
  logic [19:0] flip_mask;
  logic        overall_err;

  // Recompute the parity of the received data bits.
  always_comb begin
    parity_out = '0;
    enc_pos    = '0;
    for (int i = 0; i < 20; i++) begin
      enc_pos = data_pos(i);
      for (int k = 0; k < 5; k++) begin
        if (enc_pos[k]) parity_out[k] = parity_out[k] ^ data_in[i];
      end
    end
    parity_out[5] = (^data_in) ^ (^parity_out[4:0]);
  end

  // Classify the syndrome and correct a single data-bit error.
  // The stored overall bit is compared against recomputed checks, so the
  // true codeword parity error is syndrome[5] folded with the check syndrome.
  always_comb begin
    syndrome    = parity_in ^ parity_out;
    overall_err = syndrome[5] ^ (^syndrome[4:0]);
    sbit_err    = overall_err && (syndrome[4:0] <= 5'd25);
    dbit_err    = (syndrome != 6'd0) && !sbit_err;
    flip_mask   = '0;
    dec_pos     = '0;
    for (int i = 0; i < 20; i++) begin
      dec_pos = data_pos(i);
      if (dec_pos == syndrome[4:0]) flip_mask[i] = 1'b1;
    end
    // Parity-only errors land on positions 0/1/2/4/8/16 and leave data alone;
    // uncorrectable words are passed through uncorrected.
    data_out = sbit_err ? (data_in ^ flip_mask) : data_in;
  end

endmodule

module ecc_20_chk_pipe #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [19:0]           in_data,
  input  logic [5:0]            in_parity,
  input  logic                  bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [19:0]           out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_sbit_err,
  output logic                  out_dbit_err,
  input  logic                  clr_log,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_dbit,
  output logic [5:0]            err_syndrome,
  output logic                  irq
);

  typedef struct packed {
    logic [19:0]           data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  sbit;
    logic                  dbit;
  } word_t;

  logic [5:0]  dec_parity;
  logic [5:0]  dec_syndrome;
  logic [19:0] dec_data;
  logic        dec_sbit;
  logic        dec_dbit;

  word_t in_word;
  word_t out_q;
  word_t skid_q;
  logic  out_valid_q;
  logic  skid_full_q;
  logic  accept;

  ecc_20_cal u_cal (
    .data_in    (in_data),
    .parity_in  (in_parity),
    .parity_out (dec_parity),
    .syndrome   (dec_syndrome),
    .data_out   (dec_data),
    .sbit_err   (dec_sbit),
    .dbit_err   (dec_dbit)
  );

  // Decode result travels with the word; bypass passes raw data, no flags.
  always_comb begin
    in_word.data = bypass ? in_data : dec_data;
    in_word.addr = in_addr;
    in_word.sbit = !bypass && dec_sbit;
    in_word.dbit = !bypass && dec_dbit;
  end

  assign in_ready = !skid_full_q;
  assign accept   = in_valid && in_ready;

  // Two-entry skid buffer: output register first, skid register on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      if (!out_valid_q || out_ready) begin
        if (skid_full_q) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
          skid_full_q <= 1'b0;
        end else if (accept) begin
          out_q       <= in_word;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q      <= in_word;
        skid_full_q <= 1'b1;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_q.data;
  assign out_addr     = out_q.addr;
  assign out_sbit_err = out_q.sbit;
  assign out_dbit_err = out_q.dbit;

`ifdef ECC_20_CHK_ERR_LOG_EN
  logic [CNT_WIDTH-1:0]  sbit_cnt_q, dbit_cnt_q;
  logic [CNT_WIDTH-1:0]  sbit_base, dbit_base;
  logic [CNT_WIDTH-1:0]  sbit_nxt, dbit_nxt;
  logic                  cap_valid_q, cap_dbit_q;
  logic [ADDR_WIDTH-1:0] cap_addr_q;
  logic [5:0]            cap_syn_q;
  logic                  cap_valid_nxt, cap_dbit_nxt;
  logic [ADDR_WIDTH-1:0] cap_addr_nxt;
  logic [5:0]            cap_syn_nxt;
  logic                  ev_sbit, ev_dbit;
  logic                  unused_log;

  assign unused_log = ^dec_parity;

  // Next log state: clear first, then apply the accepted event.
  always_comb begin
    ev_sbit = accept && in_word.sbit;
    ev_dbit = accept && in_word.dbit;

    sbit_base = clr_log ? '0 : sbit_cnt_q;
    dbit_base = clr_log ? '0 : dbit_cnt_q;
    sbit_nxt  = sbit_base;
    dbit_nxt  = dbit_base;
    if (ev_sbit && (sbit_base != '1)) sbit_nxt = sbit_base + CNT_WIDTH'(1);
    if (ev_dbit && (dbit_base != '1)) dbit_nxt = dbit_base + CNT_WIDTH'(1);

    cap_valid_nxt = clr_log ? 1'b0 : cap_valid_q;
    cap_dbit_nxt  = clr_log ? 1'b0 : cap_dbit_q;
    cap_addr_nxt  = clr_log ? '0   : cap_addr_q;
    cap_syn_nxt   = clr_log ? '0   : cap_syn_q;
    // Load on first error, or upgrade a captured sbit to a new dbit.
    if ((ev_sbit || ev_dbit) &&
        (!cap_valid_nxt || (ev_dbit && !cap_dbit_nxt))) begin
      cap_valid_nxt = 1'b1;
      cap_dbit_nxt  = ev_dbit;
      cap_addr_nxt  = in_addr;
      cap_syn_nxt   = dec_syndrome;
    end
  end

  // Error statistics and first-error capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      cap_valid_q <= 1'b0;
      cap_dbit_q  <= 1'b0;
      cap_addr_q  <= '0;
      cap_syn_q   <= '0;
    end else begin
      sbit_cnt_q  <= sbit_nxt;
      dbit_cnt_q  <= dbit_nxt;
      cap_valid_q <= cap_valid_nxt;
      cap_dbit_q  <= cap_dbit_nxt;
      cap_addr_q  <= cap_addr_nxt;
      cap_syn_q   <= cap_syn_nxt;
    end
  end

  assign sbit_cnt     = sbit_cnt_q;
  assign dbit_cnt     = dbit_cnt_q;
  assign err_valid    = cap_valid_q;
  assign err_addr     = cap_addr_q;
  assign err_dbit     = cap_dbit_q;
  assign err_syndrome = cap_syn_q;
  assign irq          = cap_valid_q;
`else
  logic unused_log;

  assign unused_log   = ^{clr_log, dec_syndrome, dec_parity};
  assign sbit_cnt     = '0;
  assign dbit_cnt     = '0;
  assign err_valid    = 1'b0;
  assign err_addr     = '0;
  assign err_dbit     = 1'b0;
  assign err_syndrome = '0;
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_20_chk_pipe.sv
// Testbench for ecc_20_chk_pipe: table of decode vectors plus hand-written
// sequences for logging, backpressure, saturation/clear and async reset.
// Logging expectations follow ECC_20_CHK_ERR_LOG_EN.
module tb_ecc_20_chk_pipe;

`ifdef ECC_20_CHK_ERR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_addr;
  logic [19:0] in_data;
  logic [5:0]  in_parity;
  logic        bypass;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic [7:0]  out_addr;
  logic        out_sbit_err;
  logic        out_dbit_err;
  logic        clr_log;
  logic [7:0]  sbit_cnt;
  logic [7:0]  dbit_cnt;
  logic        err_valid;
  logic [7:0]  err_addr;
  logic        err_dbit;
  logic [5:0]  err_syndrome;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int rx    = 0;
  bit mon_en = 1'b0;
  logic [19:0] exp_q[$];

  ecc_20_chk_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_parity(in_parity),
    .bypass(bypass), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_sbit_err(out_sbit_err),
    .out_dbit_err(out_dbit_err), .clr_log(clr_log), .sbit_cnt(sbit_cnt),
    .dbit_cnt(dbit_cnt), .err_valid(err_valid), .err_addr(err_addr),
    .err_dbit(err_dbit), .err_syndrome(err_syndrome), .irq(irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reference SECDED encoder built from codeword positions.
  function automatic logic [5:0] enc(input logic [19:0] d);
    logic [25:0] cw;
    logic [5:0]  p;
    int j;
    cw = '0;
    j  = 0;
    for (int pos = 1; pos <= 25; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[j];
        j++;
      end
    end
    p = '0;
    for (int k = 0; k < 5; k++)
      for (int pos = 1; pos <= 25; pos++)
        if (((pos >> k) & 1) == 1) p[k] = p[k] ^ cw[pos];
    p[5] = (^d) ^ (^p[4:0]);
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver: present one word for one clock edge, return #1 after it.
  task automatic send(input logic [19:0] d, input logic [5:0] p,
                      input logic [7:0] a, input logic byp);
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    in_addr   = a;
    bypass    = byp;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bypass   = 1'b0;
  endtask

  // Scoreboard monitor for the backpressure sequence.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL bp_extra actual=%0h expected=none", out_data);
      end else begin
        chk("bp_order", {12'h0, out_data}, {12'h0, exp_q.pop_front()});
        rx++;
      end
    end
  end

  typedef struct {
    logic [19:0] base;
    logic [19:0] dflip;
    logic [5:0]  pflip;
    logic        byp;
    logic [19:0] exp_data;
    logic        exp_s;
    logic        exp_d;
  } vec_t;

  vec_t vecs[10];
  int   exp_s_cnt;
  int   exp_d_cnt;

  localparam logic [19:0] W0 = 20'h11111;
  localparam logic [19:0] W1 = 20'h22222;
  localparam logic [19:0] W2 = 20'h33333;

  initial begin
    vecs[0] = '{20'hA5A5A, 20'h00000, 6'h00, 1'b0, 20'hA5A5A, 1'b0, 1'b0};
    vecs[1] = '{20'h00000, 20'h00080, 6'h00, 1'b0, 20'h00000, 1'b1, 1'b0};
    vecs[2] = '{20'h12345, 20'h00001, 6'h00, 1'b0, 20'h12345, 1'b1, 1'b0};
    vecs[3] = '{20'hFFFFF, 20'h80000, 6'h00, 1'b0, 20'hFFFFF, 1'b1, 1'b0};
    vecs[4] = '{20'h0F0F0, 20'h00000, 6'h04, 1'b0, 20'h0F0F0, 1'b1, 1'b0};
    vecs[5] = '{20'h55555, 20'h00408, 6'h00, 1'b0, 20'h5515D, 1'b0, 1'b1};
    vecs[6] = '{20'h33333, 20'h00020, 6'h00, 1'b1, 20'h33313, 1'b0, 1'b0};
    vecs[7] = '{20'h00000, 20'h00000, 6'h20, 1'b0, 20'h00000, 1'b1, 1'b0};
    vecs[8] = '{20'h7FFFF, 20'h00000, 6'h00, 1'b0, 20'h7FFFF, 1'b0, 1'b0};
    vecs[9] = '{20'hABCDE, 20'h00000, 6'h03, 1'b0, 20'hABCDE, 1'b0, 1'b1};

    in_valid = 1'b0; in_addr = '0; in_data = '0; in_parity = '0;
    bypass = 1'b0; out_ready = 1'b1; clr_log = 1'b0;
    do_reset();

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_flags", {out_sbit_err, out_dbit_err}, 0);
    chk("rst_cnts", {sbit_cnt, dbit_cnt}, 0);
    chk("rst_err", {err_valid, err_addr, err_dbit, err_syndrome, irq}, 0);

    // Table-driven decode vectors, back to back with out_ready=1
    exp_s_cnt = 0;
    exp_d_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].base ^ vecs[i].dflip, enc(vecs[i].base) ^ vecs[i].pflip,
           8'(8'h10 + i), vecs[i].byp);
      exp_s_cnt += int'(vecs[i].exp_s);
      exp_d_cnt += int'(vecs[i].exp_d);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_addr", i), out_addr, 32'(8'h10 + i));
      chk($sformatf("vec%0d_sbit", i), out_sbit_err, vecs[i].exp_s);
      chk($sformatf("vec%0d_dbit", i), out_dbit_err, vecs[i].exp_d);
      chk($sformatf("vec%0d_scnt", i), sbit_cnt, LOG_EN ? exp_s_cnt : 0);
      chk($sformatf("vec%0d_dcnt", i), dbit_cnt, LOG_EN ? exp_d_cnt : 0);
    end
    // First error was vec1 (addr 0x11), upgraded by dbit vec5 (addr 0x15)
    chk("tbl_err_addr", err_addr, LOG_EN ? 8'h15 : 8'h00);
    chk("tbl_err_dbit", err_dbit, LOG_EN ? 1 : 0);

    // Capture: sbit at 3, dbit at 9, then sbit at 12 must not disturb it
    do_reset();
    send(20'h00080, 6'h00, 8'd3, 1'b0);
    chk("cap1_out_data", out_data, 20'h00000);
    chk("cap1_out_sbit", out_sbit_err, 1);
    chk("cap1_sbit_cnt", sbit_cnt, LOG_EN ? 1 : 0);
    chk("cap1_err_valid", err_valid, LOG_EN ? 1 : 0);
    chk("cap1_err_addr", err_addr, LOG_EN ? 3 : 0);
    chk("cap1_err_dbit", err_dbit, 0);
    chk("cap1_syndrome", err_syndrome, LOG_EN ? 6'b101100 : 6'b000000);
    chk("cap1_irq", irq, LOG_EN ? 1 : 0);
    send(20'h00408, 6'h00, 8'd9, 1'b0);
    chk("cap2_out_dbit", out_dbit_err, 1);
    chk("cap2_err_addr", err_addr, LOG_EN ? 9 : 0);
    chk("cap2_err_dbit", err_dbit, LOG_EN ? 1 : 0);
    chk("cap2_sbit_cnt", sbit_cnt, LOG_EN ? 1 : 0);
    chk("cap2_dbit_cnt", dbit_cnt, LOG_EN ? 1 : 0);
    send(20'h00001, enc(20'h0), 8'd12, 1'b0);
    chk("cap3_err_addr", err_addr, LOG_EN ? 9 : 0);
    chk("cap3_sbit_cnt", sbit_cnt, LOG_EN ? 2 : 0);
    clr_log = 1'b1;
    @(posedge clk);
    #1 clr_log = 1'b0;
    chk("clr_cnts", {sbit_cnt, dbit_cnt}, 0);
    chk("clr_err", {err_valid, err_addr, err_dbit, err_syndrome, irq}, 0);

    // Backpressure: 3 words offered while out_ready=0
    mon_en    = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1; in_addr = 8'h30; in_data = W0; in_parity = enc(W0);
    @(posedge clk); #1;
    chk("bp_ready_1", in_ready, 1);
    chk("bp_valid_1", out_valid, 1);
    chk("bp_data_1", out_data, W0);
    exp_q.push_back(W0);
    in_addr = 8'h31; in_data = W1; in_parity = enc(W1);
    @(posedge clk); #1;
    chk("bp_ready_fall", in_ready, 0);
    exp_q.push_back(W1);
    in_addr = 8'h32; in_data = W2; in_parity = enc(W2);
    @(posedge clk); #1;
    chk("bp_ready_held", in_ready, 0);
    chk("bp_stable", out_data, W0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_rise", in_ready, 1);
    chk("bp_data_2", out_data, W1);
    exp_q.push_back(W2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_data_3", out_data, W2);
    @(posedge clk); #1;
    chk("bp_drained", out_valid, 0);
    chk("bp_queue_empty", exp_q.size(), 0);
    chk("bp_rx_count", rx, 3);
    mon_en = 1'b0;

    // Saturation then clear coinciding with events
    for (int i = 0; i < 260; i++) send(20'h00080, 6'h00, 8'(i), 1'b0);
    chk("sat_sbit_cnt", sbit_cnt, LOG_EN ? 255 : 0);
    chk("sat_err_addr", err_addr, 0);
    clr_log = 1'b1;
    send(20'h00408, 6'h00, 8'h77, 1'b0);
    clr_log = 1'b0;
    chk("clrd_sbit_cnt", sbit_cnt, 0);
    chk("clrd_dbit_cnt", dbit_cnt, LOG_EN ? 1 : 0);
    chk("clrd_err_addr", err_addr, LOG_EN ? 8'h77 : 8'h00);
    chk("clrd_err_dbit", err_dbit, LOG_EN ? 1 : 0);
    clr_log = 1'b1;
    send(20'h00080, 6'h00, 8'h42, 1'b0);
    clr_log = 1'b0;
    chk("clrs_sbit_cnt", sbit_cnt, LOG_EN ? 1 : 0);
    chk("clrs_dbit_cnt", dbit_cnt, 0);
    chk("clrs_err_addr", err_addr, LOG_EN ? 8'h42 : 8'h00);
    chk("clrs_err_dbit", err_dbit, 0);
    chk("clrs_syndrome", err_syndrome, LOG_EN ? 6'b101100 : 6'b000000);

    // Asynchronous reset with both entries occupied
    out_ready = 1'b0;
    send(W1, enc(W1), 8'h50, 1'b0);
    send(W2, enc(W2), 8'h51, 1'b0);
    chk("ar_full_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out_data", out_data, 0);
    chk("ar_err", {err_valid, sbit_cnt}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ar_after_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
